// File: rtl/piso_serializer_if.sv
// Producer/link bundle for the parallel-in serial-out transmitter.
// Latency: none, this is wiring only.
// Backpressure: ready from the transmitter gates valid from the producer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  // Producer side of the handshake plus the synchronous abort.
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;

  // Link wires and status back toward the producer.
  logic             ser_out;
  logic             ser_en;
  logic             busy;
  logic             done;

  // Producer (or testbench) drives the word and the abort.
  modport master (
    output clear,
    output data_in,
    output valid,
    input  ready,
    input  ser_out,
    input  ser_en,
    input  busy,
    input  done
  );

  // The serializer consumes the word and drives the link.
  modport slave (
    input  clear,
    input  data_in,
    input  valid,
    output ready,
    output ser_out,
    output ser_en,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word, shifts it out MSB first, DIV cycles per bit.
// Latency: first ser_en DIV cycles after the accept, done WIDTH*DIV+1 cycles after, ready again one cycle later.
// Backpressure: ready is high only in IDLE; valid seen while ready is low is ignored, never queued.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic              clock,
  input  logic              reset_L,
  piso_serializer_if.slave  bus
);

  // Counter widths: bit_cnt counts down WIDTH-1..0, div_cnt counts up 0..DIV-1.
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(DIV + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ZERO = '0;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ZERO = '0;
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_shreg;
  logic [WIDTH-1:0]  w_shreg_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic [DW-1:0]     r_div_cnt;
  logic [DW-1:0]     w_div_cnt_nxt;

  // Last cycle of the current bit period; with DIV=1 this is every SEND cycle.
  logic              w_bit_tick;
  logic              w_in_send;

  assign w_in_send  = (r_state == S_SEND);
  assign w_bit_tick = (r_div_cnt == DIV_LAST);

  // State register and datapath registers; reset drops everything to an idle, zeroed link.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  // Next-state and datapath update; clear overrides everything, including a word offered the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = r_div_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (bus.valid) begin
          w_state_nxt   = S_SEND;
          w_shreg_nxt   = bus.data_in;
          w_bit_cnt_nxt = BIT_LAST;
          w_div_cnt_nxt = DIV_ZERO;
        end
      end

      S_SEND: begin
        if (w_bit_tick) begin
          // Bit period over: move the next bit into the MSB slot.
          w_div_cnt_nxt = DIV_ZERO;
          w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
          if (r_bit_cnt == BIT_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - BIT_ONE;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_ONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = BIT_ZERO;
        w_div_cnt_nxt = DIV_ZERO;
      end
    endcase

    // Abort leaves the shift register holding whatever it had; only control state is reset.
    if (bus.clear) begin
      w_state_nxt   = S_IDLE;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = BIT_ZERO;
      w_div_cnt_nxt = DIV_ZERO;
    end
  end

  // Outputs decode registered state only, so nothing here depends combinationally on the inputs.
  always_comb begin
    bus.ready   = (r_state == S_IDLE);
    bus.busy    = w_in_send;
    bus.done    = (r_state == S_DONE);
    bus.ser_en  = w_in_send && w_bit_tick;
    bus.ser_out = w_in_send && r_shreg[WIDTH-1];
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one instance at DIV=1, one at DIV=4, WIDTH=8.
// A monitor rebuilds each word from ser_out/ser_en and checks it against a queue filled at accept time.
// Directed sequences additionally check cycle-exact timing of strobes, done and ready.
module tb_piso_serializer;

  logic clock;
  logic rst1_n;
  logic rst4_n;

  int total;
  int bad;
  int done_cnt1;
  int done_cnt4;

  logic [7:0] q1[$];
  logic [7:0] q4[$];

  piso_serializer_if #(.WIDTH(8)) b1 ();
  piso_serializer_if #(.WIDTH(8)) b4 ();

  piso_serializer #(.WIDTH(8), .DIV(1)) u_div1 (
    .clock   (clock),
    .reset_L (rst1_n),
    .bus     (b1)
  );

  piso_serializer #(.WIDTH(8), .DIV(4)) u_div4 (
    .clock   (clock),
    .reset_L (rst4_n),
    .bus     (b4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ready, busy, ser_en, ser_out, done}
  function automatic logic [4:0] st(input int d);
    if (d == 4) return {b4.ready, b4.busy, b4.ser_en, b4.ser_out, b4.done};
    return {b1.ready, b1.busy, b1.ser_en, b1.ser_out, b1.done};
  endfunction

  // Offer a word while the DUT is idle; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [7:0] w);
    check("accept_ready", st(d) >> 4, 32'd1);
    if (d == 4) begin
      b4.data_in = w;
      b4.valid   = 1'b1;
      q4.push_back(w);
    end else begin
      b1.data_in = w;
      b1.valid   = 1'b1;
      q1.push_back(w);
    end
    @(posedge clock);
    #1;
    if (d == 4) b4.valid = 1'b0;
    else        b1.valid = 1'b0;
  endtask

  // Cycle-by-cycle expectations for the nc cycles following an accept.
  task automatic walk(input int d, input int div, input int nc, input logic [7:0] w);
    logic [4:0] e;
    logic       bsy;
    for (int m = 1; m <= nc; m++) begin
      @(negedge clock);
      bsy  = (m <= 8 * div);
      e[4] = (m >= 8 * div + 2);
      e[3] = bsy;
      e[2] = bsy && ((m % div) == 0);
      e[1] = bsy ? w[7 - (m - 1) / div] : 1'b0;
      e[0] = (m == 8 * div + 1);
      check($sformatf("walk_d%0d_m%0d", d, m), st(d), e);
    end
  endtask

  // Monitor for the DIV=1 instance: reference SIPO plus scoreboard pop on done.
  initial begin
    logic [7:0] sipo;
    logic [7:0] exp;
    int         nb;
    sipo = '0;
    nb   = 0;
    forever begin
      @(negedge clock);
      if (!rst1_n) begin
        sipo = '0;
        nb   = 0;
      end else begin
        if (b1.ready) nb = 0;
        if (b1.ser_en) begin
          sipo = {sipo[6:0], b1.ser_out};
          nb++;
        end
        if (b1.done) begin
          done_cnt1++;
          if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done1: got done=1 expected no done at %0t", $time);
          end else begin
            exp = q1.pop_front();
            check("word1", sipo, exp);
            check("nstrobe1", nb, 8);
          end
        end
      end
    end
  end

  // Monitor for the DIV=4 instance.
  initial begin
    logic [7:0] sipo;
    logic [7:0] exp;
    int         nb;
    sipo = '0;
    nb   = 0;
    forever begin
      @(negedge clock);
      if (!rst4_n) begin
        sipo = '0;
        nb   = 0;
      end else begin
        if (b4.ready) nb = 0;
        if (b4.ser_en) begin
          sipo = {sipo[6:0], b4.ser_out};
          nb++;
        end
        if (b4.done) begin
          done_cnt4++;
          if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done4: got done=1 expected no done at %0t", $time);
          end else begin
            exp = q4.pop_front();
            check("word4", sipo, exp);
            check("nstrobe4", nb, 8);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int s;
    int dc;
    total = 0;
    bad   = 0;
    done_cnt1 = 0;
    done_cnt4 = 0;
    b1.clear = 1'b0; b1.valid = 1'b0; b1.data_in = '0;
    b4.clear = 1'b0; b4.valid = 1'b0; b4.data_in = '0;
    rst1_n = 1'b0;
    rst4_n = 1'b0;

    // Reset, then idle.
    repeat (3) begin
      @(negedge clock);
      check("reset_d1", st(1), 5'b10000);
      check("reset_d4", st(4), 5'b10000);
    end
    @(posedge clock);
    #1;
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("idle_d1", st(1), 5'b10000);
      check("idle_d4", st(4), 5'b10000);
    end

    // Basic transfer at DIV=1.
    send(1, 8'hA5);
    walk(1, 1, 10, 8'hA5);

    // Back-to-back with valid held and data changing mid-transfer.
    b1.data_in = 8'hFF;
    b1.valid   = 1'b1;
    q1.push_back(8'hFF);
    @(posedge clock);
    #1;
    n = 0;
    while (n < 30) begin
      @(negedge clock);
      n++;
      if (n == 4) b1.data_in = 8'h01;
      if (b1.ready) break;
    end
    check("b2b_spacing", n, 10);
    q1.push_back(8'h01);
    @(posedge clock);
    #1;
    b1.valid = 1'b0;
    walk(1, 1, 10, 8'h01);

    // Abort after the third strobe.
    send(1, 8'h96);
    s = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (b1.ser_en) s++;
      if (s == 3) break;
    end
    check("abort_strobes_seen", s, 3);
    b1.clear = 1'b1;
    dc = done_cnt1;
    @(posedge clock);
    #1;
    b1.clear = 1'b0;
    void'(q1.pop_back());
    @(negedge clock);
    check("abort_idle", st(1), 5'b10000);
    repeat (12) begin
      @(negedge clock);
      check("abort_quiet", st(1), 5'b10000);
    end
    check("abort_no_done", done_cnt1, dc);

    // clear wins over valid in the same cycle.
    b1.clear   = 1'b1;
    b1.valid   = 1'b1;
    b1.data_in = 8'h77;
    @(posedge clock);
    #1;
    b1.clear = 1'b0;
    b1.valid = 1'b0;
    @(negedge clock);
    check("clear_prio", st(1), 5'b10000);

    send(1, 8'h5A);
    walk(1, 1, 10, 8'h5A);

    // Divided rate.
    @(negedge clock);
    send(4, 8'h3C);
    walk(4, 4, 34, 8'h3C);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clock);
    send(4, 8'hC3);
    repeat (4) @(negedge clock);
    check("pre_async_rst", st(4), 5'b01110);
    #2;
    rst4_n = 1'b0;
    #1;
    check("async_rst", st(4), 5'b10000);
    void'(q4.pop_back());
    dc = done_cnt4;
    repeat (2) @(posedge clock);
    #1;
    rst4_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      check("post_rst_quiet", st(4), 5'b10000);
    end
    check("post_rst_no_done", done_cnt4, dc);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
